// File: rtl/xs3_seg_scan.sv
// xs3_seg_scan
// Takes a two-digit excess-3 word over a valid/ready handshake and validates
// both codes. Valid words are shown on a two-digit seven-segment display, with
// the units and tens digits lit in turn and a zero tens digit blanked. A word
// with an invalid code shows dashes on both digits and raises err.
module xs3_seg_scan #(
    parameter int REFRESH_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] xs3_hi,
    input  logic [3:0] xs3_lo,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    localparam logic [1:0] AN_NONE  = 2'b00;
    localparam logic [1:0] AN_UNITS = 2'b01;
    localparam logic [1:0] AN_TENS  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW,
        ERR
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             dsel;
    logic             dsel_d;
    logic [6:0]       seg_d;
    logic [1:0]       an_d;
    logic             err_d;

    logic [3:0]       hi_q;
    logic [3:0]       lo_q;
    logic [3:0]       tens_bcd;
    logic [3:0]       units_bcd;
    logic             word_ok;
    logic             handshake;

    // A digit code is legal excess-3 only for decimal 0..9 (0011..1100).
    function automatic logic code_ok(input logic [3:0] code);
        return (code >= 4'd3) && (code <= 4'd12);
    endfunction

    // Segment pattern {a,b,c,d,e,f,g} for one BCD digit.
    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1111110;
            4'd1:    p = 7'b0110000;
            4'd2:    p = 7'b1101101;
            4'd3:    p = 7'b1111001;
            4'd4:    p = 7'b0110011;
            4'd5:    p = 7'b1011011;
            4'd6:    p = 7'b1011111;
            4'd7:    p = 7'b1110000;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1111011;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // Display image {seg, an, err} for a given mode and selected digit.
    // Dashes are never blanked; in normal mode only a zero tens digit is.
    function automatic logic [9:0] scan_image(
        input logic       show_dash,
        input logic       sel,
        input logic [3:0] tens,
        input logic [3:0] units
    );
        logic [9:0] img;
        if (show_dash) begin
            img = {SEG_DASH, (sel ? AN_TENS : AN_UNITS), 1'b1};
        end else if (!sel) begin
            img = {digit_seg(units), AN_UNITS, 1'b0};
        end else if (tens == 4'd0) begin
            img = {SEG_BLANK, AN_NONE, 1'b0};
        end else begin
            img = {digit_seg(tens), AN_TENS, 1'b0};
        end
        return img;
    endfunction

    // Upstream may only transfer while we are not busy decoding a word.
    assign in_ready  = (state != LOAD);
    assign handshake = in_valid && in_ready;

    assign tens_bcd  = hi_q - 4'd3;
    assign units_bcd = lo_q - 4'd3;
    assign word_ok   = code_ok(hi_q) && code_ok(lo_q);

    // Capture the incoming word on every accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 4'd0;
            lo_q <= 4'd0;
        end else if (handshake) begin
            hi_q <= xs3_hi;
            lo_q <= xs3_lo;
        end
    end

    // Next-state, scan counter and registered display image.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        dsel_d  = dsel;
        seg_d   = seg;
        an_d    = an;
        err_d   = err;

        case (state)
            IDLE: begin
                seg_d = SEG_BLANK;
                an_d  = AN_NONE;
                err_d = 1'b0;
                if (handshake) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                cnt_d  = '0;
                dsel_d = 1'b0;
                state_d = word_ok ? SHOW : ERR;
                {seg_d, an_d, err_d} = scan_image(!word_ok, 1'b0,
                                                  tens_bcd, units_bcd);
            end

            SHOW, ERR: begin
                if (handshake) begin
                    state_d = LOAD;
                end else begin
                    if (cnt == CNT_LAST) begin
                        cnt_d  = '0;
                        dsel_d = ~dsel;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                    {seg_d, an_d, err_d} = scan_image(state == ERR, dsel_d,
                                                      tens_bcd, units_bcd);
                end
            end

            default: begin
                state_d = IDLE;
                seg_d   = SEG_BLANK;
                an_d    = AN_NONE;
                err_d   = 1'b0;
            end
        endcase
    end

    // State, scan position and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dsel  <= 1'b0;
            seg   <= SEG_BLANK;
            an    <= AN_NONE;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            dsel  <= dsel_d;
            seg   <= seg_d;
            an    <= an_d;
            err   <= err_d;
        end
    end

endmodule

// File: tb/tb_xs3_seg_scan.sv
// Directed bench for xs3_seg_scan with a short refresh period.
module tb_xs3_seg_scan;

    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] xs3_hi;
    logic [3:0] xs3_lo;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int vectors;
    int miscompares;

    xs3_seg_scan #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .xs3_hi   (xs3_hi),
        .xs3_lo   (xs3_lo),
        .seg      (seg),
        .an       (an),
        .err      (err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [6:0] e_seg,
                             input logic [1:0] e_an, input logic e_err,
                             input logic e_ready);
        check_output({tag, ".seg"},      {1'b0, seg},        {1'b0, e_seg});
        check_output({tag, ".an"},       {6'd0, an},         {6'd0, e_an});
        check_output({tag, ".err"},      {7'd0, err},        {7'd0, e_err});
        check_output({tag, ".in_ready"}, {7'd0, in_ready},   {7'd0, e_ready});
    endtask

    // Present a word for exactly one accepted edge; returns sampled in LOAD.
    task automatic apply_stimulus(input logic [3:0] hi, input logic [3:0] lo);
        xs3_hi   = hi;
        xs3_lo   = lo;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_output("load.in_ready", {7'd0, in_ready}, 8'd0);
    endtask

    // Check scan cycles first_k..first_k+n-1 (cycle 0 = first after LOAD).
    task automatic scan_check(input string tag, input logic [6:0] u_seg,
                              input logic [1:0] t_an, input logic [6:0] t_seg,
                              input logic e_err, input int first_k, input int n);
        for (int k = first_k; k < first_k + n; k++) begin
            logic tens_phase;
            tick();
            tens_phase = ((k / DIV) % 2) == 1;
            if (tens_phase)
                check_all($sformatf("%s.c%0d", tag, k), t_seg, t_an, e_err, 1'b1);
            else
                check_all($sformatf("%s.c%0d", tag, k), u_seg, 2'b01, e_err, 1'b1);
        end
    endtask

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        xs3_hi      = 4'd0;
        xs3_lo      = 4'd0;

        // Reset held, then released between edges.
        #22;
        check_all("rst_hold", 7'b0000000, 2'b00, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all($sformatf("idle%0d", i), 7'b0000000, 2'b00, 1'b0, 1'b1);
        end

        // 09: tens blanked, units 9; outputs hold blank during LOAD.
        apply_stimulus(4'b0011, 4'b1100);
        check_all("v09.load", 7'b0000000, 2'b00, 1'b0, 1'b0);
        scan_check("v09", 7'b1111011, 2'b00, 7'b0000000, 1'b0, 0, 12);

        // 00: units still shows 0, tens blanked.
        apply_stimulus(4'b0011, 4'b0011);
        scan_check("v00", 7'b1111110, 2'b00, 7'b0000000, 1'b0, 0, 8);

        // Invalid low code: dashes on both digits, err set.
        apply_stimulus(4'b0011, 4'b0000);
        scan_check("bad_lo", 7'b0000001, 2'b10, 7'b0000001, 1'b1, 0, 8);

        // 11 clears err only at LOAD exit.
        apply_stimulus(4'b0100, 4'b0100);
        check_output("v11.load.err", {7'd0, err}, 8'd1);
        scan_check("v11", 7'b0110000, 2'b10, 7'b0110000, 1'b0, 0, 8);

        // Invalid high code 1101 just above the legal range.
        apply_stimulus(4'b1101, 4'b0011);
        scan_check("bad_hi", 7'b0000001, 2'b10, 7'b0000001, 1'b1, 0, 4);

        // 15, then reload 24 while on the tens digit at its last count.
        apply_stimulus(4'b0100, 4'b1000);
        scan_check("v15", 7'b1011011, 2'b10, 7'b0110000, 1'b0, 0, 8);
        xs3_hi   = 4'b0101;
        xs3_lo   = 4'b0111;
        in_valid = 1'b1;
        tick();
        check_all("reload.load", 7'b0110000, 2'b10, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check_all("reload.c0", 7'b0110011, 2'b01, 1'b0, 1'b1);
        scan_check("v24", 7'b0110011, 2'b10, 7'b1101101, 1'b0, 1, 7);

        // Asynchronous reset between edges, mid-scan.
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 7'b0000000, 2'b00, 1'b0, 1'b1);
        #2;
        rst_n = 1'b1;
        tick();
        check_all("post_rst", 7'b0000000, 2'b00, 1'b0, 1'b1);

        // 38 after reset behaves as from power-up.
        apply_stimulus(4'b0110, 4'b1011);
        check_all("v38.load", 7'b0000000, 2'b00, 1'b0, 1'b0);
        scan_check("v38", 7'b1111111, 2'b10, 7'b1111001, 1'b0, 0, 8);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xs3_seg_scan.md
# xs3_seg_scan

Downstream display stage for the binary→BCD→excess-3 converter. It accepts one two-digit excess-3 word (tens, units) over a valid/ready handshake and checks each code. It converts the word back to BCD and drives a time-multiplexed two-digit seven-segment display with leading-zero blanking. Invalid codes raise a sticky error and show dashes.

## Interface
- REFRESH_DIV, default 16: clock cycles each digit stays lit; legal range ≥ 2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents xs3_hi/xs3_lo.
- in_ready  output  1  block can accept a word this cycle.
- xs3_hi  input  4  tens digit, excess-3 coded.
- xs3_lo  input  4  units digit, excess-3 coded.
- seg  output  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-high.
- an  output  2  digit enables, active-high; an[0] = units, an[1] = tens.
- err  output  1  the last accepted word contained an invalid code.

## Operation
- FSM states are IDLE, LOAD, SHOW and ERR.
- **IDLE**
  - Display blank: seg = 0, an = 00, err = 0.
  - in_ready = 1.
  - A handshake moves the FSM to LOAD.
- **Handshake**
  - A transfer occurs on an edge where in_valid && in_ready.
  - xs3_hi and xs3_lo are latched on that edge.
  - in_ready = 1 in IDLE, SHOW and ERR; in_ready = 0 in LOAD.
- **LOAD** (one cycle)
  - Each latched code is valid only in 0011..1100; BCD digit = code − 3, 4-bit.
  - Both codes valid → SHOW. Either code invalid → ERR.
  - At the exit edge: refresh counter cnt ← 0, digit select dsel ← 0 (units), and seg/an/err are loaded for the new state.
  - seg/an/err hold their previous values during LOAD.
- **SHOW**
  - cnt increments every cycle.
  - At cnt == REFRESH_DIV−1: cnt ← 0 and dsel toggles.
  - dsel = 0: an = 01, seg = units pattern.
  - dsel = 1, tens BCD ≠ 0: an = 10, seg = tens pattern.
  - dsel = 1, tens BCD = 0: leading-zero blank, an = 00 and seg = 0.
  - Units digit is never blanked; value 00 displays "0".
  - err = 0.
- **ERR**
  - Same scan timing as SHOW.
  - Both digits display a dash (seg = 0000001) with no blanking.
  - err = 1 and stays set until the next handshake or reset.
- **Segment patterns (a..g)**
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
- **Simultaneous events**
  - A handshake in SHOW or ERR takes priority over the refresh terminal count.
  - FSM → LOAD; scanning restarts from units with cnt = 0 on LOAD exit.
  - in_valid during LOAD is not accepted; upstream holds its data.

## Timing
- Reset: rst_n low asynchronously forces state = IDLE, cnt = 0, dsel = 0, seg = 0, an = 00, err = 0, without waiting for a clock edge. in_ready = 1 while in IDLE.
- Handshake at edge N:
  - Cycle N..N+1 is LOAD with in_ready = 0.
  - Edge N+1 enters SHOW/ERR; an = 01 and err are valid from edge N+1.
  - Latency: one cycle from handshake to display.
- Each digit is lit exactly REFRESH_DIV cycles; the full refresh period is 2·REFRESH_DIV cycles.
- seg, an and err are registered outputs; in_ready is decoded from the state register.
- Reset asserted mid-scan or mid-LOAD discards the latched word. The first post-reset handshake behaves as if from power-up.

## Test plan
- Reset (REFRESH_DIV = 4): hold rst_n = 0, then release → seg = 0, an = 00, err = 0, in_ready = 1; the outputs stay unchanged over 20 idle cycles.
- Value 09 (xs3_hi = 0011, xs3_lo = 1100):
  - Cycles 1–4 after LOAD: an = 01, seg = 1111011.
  - Cycles 5–8: an = 00, seg = 0 (tens blanked).
  - The pattern repeats; err = 0.
- Value 15 (xs3_hi = 0100, xs3_lo = 1000): an = 01 / seg = 1011011 for 4 cycles, then an = 10 / seg = 0110000 for 4 cycles, repeating.
- Invalid code (xs3_hi = 0011, xs3_lo = 0000): one cycle later err = 1 and seg = 0000001, with an alternating 01/10 every 4 cycles. A following valid word 0100/0100 (11) clears err at LOAD exit and shows 1 on both digits.
- Mid-scan reload: while SHOW(15) is on the tens digit with cnt = 3, present 0101/0111 (24) with in_valid held two cycles.
  - in_ready = 0 for exactly one cycle, so only one transfer occurs.
  - Next: an = 01 / seg = 0110011 for 4 cycles, then an = 10 / seg = 1101101.
- Async reset mid-SHOW: drop rst_n between clock edges → seg = 0, an = 00, err = 0 before the next rising edge. After release, a new word displays normally.
